// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Holds the access-size encoding, FSM states and byte-lane math.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return (lo != 2'b00);
    endcase
  endfunction

  // Drops the low address bits that the access size cannot address.
  function automatic logic [1:0] align_lo(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return lo;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input size_e size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input size_e size, input logic [1:0] lo,
                                               input logic uns, input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (size)
      SIZE_BYTE: return uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: return uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:   return shifted;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised storage: one asynchronous read port and one byte-enabled
// write port. Contents are deliberately never reset.
module dmem_sram_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed response latency.
// Define DMEM_RESP_ERR_EN to flag and suppress misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lo_q;
  logic             we_q, uns_q;
  size_e            size_q;

  logic             accept, in_idle, enter_rsp;
  logic [IDX_W-1:0] cur_idx;
  logic [1:0]       cur_lo, aligned_lo;
  logic             cur_we, cur_uns, cur_err;
  size_e            cur_size;
  logic             wr_en;
  logic [31:0]      mem_rdata, load_data;

  assign in_idle   = (state_q == ST_IDLE);
  assign req_ready = in_idle;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;

  // In IDLE the live request drives the datapath so LATENCY==1 and the
  // accept-edge store both see it; afterwards the captured copy takes over.
  assign cur_idx  = in_idle ? req_addr[IDX_W+1:2] : idx_q;
  assign cur_lo   = in_idle ? req_addr[1:0] : lo_q;
  assign cur_we   = in_idle ? req_we : we_q;
  assign cur_uns  = in_idle ? req_unsigned : uns_q;
  assign cur_size = in_idle ? size_e'(req_size) : size_q;
  assign aligned_lo = align_lo(cur_size, cur_lo);

`ifdef DMEM_RESP_ERR_EN
  logic err_q;

  assign cur_err = is_misaligned(cur_size, cur_lo);
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (enter_rsp) err_q <= cur_err;
  end
`else
  assign cur_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign wr_en     = accept && req_we && !cur_err;
  assign load_data = (cur_we || cur_err) ? 32'h0
                   : extract_load(cur_size, aligned_lo, cur_uns, mem_rdata);

  dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .be_i    (lane_mask(cur_size, aligned_lo)),
    .waddr_i (cur_idx),
    .wdata_i (lane_data(cur_size, req_wdata)),
    .raddr_i (cur_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    enter_rsp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_RESP;
            enter_rsp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          enter_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_rsp) rdata_d = load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lo_q   <= 2'b00;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= SIZE_BYTE;
    end else if (accept) begin
      idx_q  <= req_addr[IDX_W+1:2];
      lo_q   <= req_addr[1:0];
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      size_q <= size_e'(req_size);
    end
  end

endmodule
